// File: rtl/haar_cascade_stage_evaluator.sv
// haar_cascade_stage_evaluator: per-window Haar cascade stage accumulator and thresholder with saturating sums.
// CASCADE_EARLY_REJECT_EN: when defined, a failing stage drains the rest of the window instead of evaluating on.
module haar_cascade_stage_evaluator #(
  parameter int DATA_WIDTH  = 12,
  parameter int ACC_WIDTH   = 20,
  parameter int NUM_STAGES  = 10,
  parameter int STAGE_IDX_W = 4
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_start,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_leaf_value,
  input  logic                   i_end_tree,
  input  logic                   i_end_stage,
  input  logic                   i_end_window,
  input  logic [DATA_WIDTH-1:0]  i_stage_threshold,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_candidate,
  output logic [STAGE_IDX_W-1:0] o_stage_reached
);
`ifdef CASCADE_EARLY_REJECT_EN
  localparam bit EARLY_REJECT = 1'b1;
`else
  localparam bit EARLY_REJECT = 1'b0;
`endif
  localparam logic [STAGE_IDX_W-1:0] LAST = STAGE_IDX_W'(NUM_STAGES - 1);
  localparam logic [STAGE_IDX_W-1:0] ALL = STAGE_IDX_W'(NUM_STAGES);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, EVAL, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_sat;
  logic signed [ACC_WIDTH-1:0]  thr_ext;
  logic signed [ACC_WIDTH:0]    sum;
  logic signed [DATA_WIDTH-1:0] leaf;
  logic signed [DATA_WIDTH-1:0] thr;
  logic [STAGE_IDX_W-1:0]       stage;
  logic [STAGE_IDX_W-1:0]       first_fail;
  logic [7:0]                   tree_cnt;
  logic                         win_end;
  logic                         fail_seen;
  logic                         accept;
  logic                         beat_end;
  logic                         pass;
  logic                         is_last;
  logic                         any_fail;
  logic                         early_fail;
  logic                         finish;
  logic                         unused_tree_cnt;

  assign o_ready = (state == ACCUM) | (state == DRAIN);
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign accept = i_valid & o_ready;
  assign beat_end = i_end_stage | i_end_window;
  assign leaf = i_leaf_value;
  assign sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(leaf);
  assign acc_sat = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
  assign thr_ext = ACC_WIDTH'(thr);
  assign pass = acc >= thr_ext;
  assign is_last = stage == LAST;
  assign any_fail = fail_seen | ~pass;
  assign early_fail = EARLY_REJECT & ~pass;
  // o_stage_reached doubles as the first-failure latch once fail_seen is set
  assign first_fail = fail_seen ? o_stage_reached : stage;
  assign finish = early_fail | is_last | win_end;
  assign unused_tree_cnt = ^tree_cnt;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_start ? ACCUM : IDLE;
      ACCUM:   state_nx = (accept && beat_end) ? EVAL : ACCUM;
      EVAL:    state_nx = !finish ? ACCUM : (win_end ? DONE : DRAIN);
      DRAIN:   state_nx = (accept && i_end_window) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga)
    if (!reset_fpga) begin
      state <= IDLE;
      acc <= '0;
      thr <= '0;
      stage <= '0;
      win_end <= 1'b0;
      fail_seen <= 1'b0;
      tree_cnt <= '0;
      o_candidate <= 1'b0;
      o_stage_reached <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start) begin
        acc <= '0;
        stage <= '0;
        win_end <= 1'b0;
        fail_seen <= 1'b0;
        tree_cnt <= '0;
        o_candidate <= 1'b0;
        o_stage_reached <= '0;
      end else if (state == ACCUM && accept) begin
        acc <= acc_sat;
        tree_cnt <= tree_cnt + 8'(i_end_tree);
        if (beat_end) begin
          thr <= i_stage_threshold;
          win_end <= i_end_window;
        end
      end else if (state == EVAL) begin
        o_candidate <= is_last & ~any_fail;
        o_stage_reached <= any_fail ? first_fail : (is_last ? ALL : stage + 1'b1);
        fail_seen <= any_fail;
        if (!finish) begin
          stage <= stage + 1'b1;
          acc <= '0;
        end
      end
    end
endmodule
